pwm_ramp_ctrl: RTL and testbench
================================

# pwm_ramp_ctrl

Soft-start duty-cycle controller for the 8-bit PWM generator. It owns a free-running period counter that stays in lockstep with the generator's counter. It accepts target duty values over a valid/ready handshake and slews the generator's duty input toward each target in fixed steps. Duty changes take effect only at period boundaries, so the generator never produces a truncated or glitched pulse.

## Interface
- `WIDTH`, 8: duty and period-counter width; period is 2^WIDTH cycles.
- `STEP`, 16: duty increment or decrement applied per ramp step; range 1..2^WIDTH-1.
- `STEP_PERIODS`, 1: number of PWM periods per ramp step; range 1..255.
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: level; 1 = run, 0 = drive duty to 0 and go idle.
- `tgt_valid` in 1: target duty offered.
- `tgt_duty` in WIDTH: requested duty.
- `tgt_ready` out 1: target accepted this cycle when `tgt_valid && tgt_ready`.
- `duty_out` out WIDTH: duty value driven to the generator.
- `period_start` out 1: one-cycle pulse on the first cycle of each period, when the counter is 0.
- `busy` out 1: high while in RAMP.
- `done` out 1: one-cycle pulse when a ramp reaches its target.

## Operation
- Period counter `cnt` (WIDTH bits) increments every cycle and wraps from 2^WIDTH-1 to 0. It is 0 in the first cycle after reset.
- Boundary event `bnd` is `cnt == 2^WIDTH-1`. All `duty_out` updates are registered on `bnd`, so the new value is visible from the cycle in which `cnt` = 0.
- States:
  - IDLE: `duty_out`=0, `tgt_ready`=0. Goes to HOLD when `enable`=1.
  - HOLD: `duty_out` is stable, `tgt_ready`=1. On handshake, latch `tgt_duty` into `tgt_q` and clear the step counter.
    - If `tgt_duty` == `duty_out`: stay in HOLD and pulse `done` next cycle.
    - Otherwise: go to RAMP.
  - RAMP: `tgt_ready`=0, `busy`=1. The step counter counts `bnd` events; on every STEP_PERIODS-th `bnd`, `duty_out` moves one step toward `tgt_q`.
    - Ramp up: `duty_out` = min(`duty_out`+STEP, `tgt_q`), computed at WIDTH+1 bits with no wrap.
    - Ramp down: `duty_out` = max(`duty_out`-STEP, `tgt_q`), computed with no underflow.
    - When the updated value equals `tgt_q`: go to HOLD and pulse `done` one cycle later, i.e. in the cycle where `cnt`=0.
- `enable` falling, in any state: `duty_out` is forced to 0 on the next `bnd`, not immediately. The state becomes IDLE at that same `bnd`. Any ramp in progress is abandoned and no `done` is issued.
- `enable` rising again before that `bnd`: the pending shutdown is cancelled and the state is unchanged.
- Handshake on the same cycle as `bnd` in HOLD: the target is latched and the first step occurs at a later `bnd`, not this one.
- Reset mid-ramp: all state returns to reset values in the next cycle. No partial step is applied.

## Timing
- Reset values: `cnt`=0, state=IDLE, `duty_out`=0, `tgt_ready`=0, `busy`=0, `done`=0, `period_start`=1 (because `cnt`=0 after reset).
- `tgt_ready` is a registered state decode and does not depend combinationally on `tgt_valid`.
- Latency from handshake to first duty change: between 1 and 2^WIDTH·STEP_PERIODS cycles, depending on counter phase.
- Ramp length: ceil(|tgt_q - duty_start| / STEP) steps.

## Structure
- `pwm_pkg` holds the state enum (`PWM_IDLE`, `PWM_HOLD`, `PWM_RAMP`) and `PWM_WIDTH_DEFAULT`=8.
- The period counter is a natural sub-module, `pwm_period_cnt`, outputting `cnt`, `bnd` and `period_start`. It is reused by the generator integration so both counters share one source.
- All logic lives in a single clocked process with synchronous reset.

## Test plan
All tests use defaults unless stated.
- Reset release, `enable`=1: HOLD reached 1 cycle after enable; `duty_out`=0; `period_start` pulses every 256 cycles starting in the cycle after reset.
- Ramp up: target 100 from 0. `duty_out` sequence is 16, 32, 48, 64, 80, 96, 100 at 7 consecutive boundaries; `done` pulses once; `tgt_ready` stays low throughout.
- Ramp down with `STEP_PERIODS`=3: target 10 from 100. Sequence is 84, 68, 52, 36, 20, 10, changing every 768 cycles.
- Saturation: `STEP`=200, target 255 from 100. Sequence is 255 in one step, with no wrap to 44. A further target of 255 gives an immediate `done` with no change to `duty_out`.
- `enable` dropped mid-ramp at duty 48: `duty_out`=0 at the next boundary, state IDLE, no `done`.
- `rst` asserted mid-ramp: all outputs take their reset values in the following cycle; the counter restarts at 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM soft-start controller and its period counter.
package pwm_pkg;
   localparam int PWM_WIDTH_DEFAULT = 8;
   localparam int PWM_STEP_CNT_W    = 8;

   typedef enum logic [1:0] {
      PWM_IDLE = 2'd0,
      PWM_HOLD = 2'd1,
      PWM_RAMP = 2'd2
   } pwm_state_e;
endpackage

// File: rtl/pwm_period_cnt.sv
// Free-running PWM period counter; shared with the generator so both see the same phase.
module pwm_period_cnt
   import pwm_pkg::*;
#(
   parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] cnt_o,
   output logic             bnd_o,
   output logic             period_start_o
);
   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb cnt_d = cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o          = cnt_q;
   assign bnd_o          = &cnt_q;
   assign period_start_o = (cnt_q == '0);
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start duty controller: slews duty toward accepted targets, updating only at period boundaries.
module pwm_ramp_ctrl
   import pwm_pkg::*;
#(
   parameter int WIDTH        = PWM_WIDTH_DEFAULT,
   parameter int STEP         = 16,
   parameter int STEP_PERIODS = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             tgt_valid,
   input  logic [WIDTH-1:0] tgt_duty,
   output logic             tgt_ready,
   output logic [WIDTH-1:0] duty_out,
   output logic             period_start,
   output logic             busy,
   output logic             done
);
   localparam logic [WIDTH:0]                STEP_X    = (WIDTH+1)'(STEP);
   localparam logic [PWM_STEP_CNT_W-1:0]     LAST_STEP = PWM_STEP_CNT_W'(STEP_PERIODS - 1);

   pwm_state_e                state_q, state_d;
   logic [WIDTH-1:0]          duty_q, duty_d;
   logic [WIDTH-1:0]          tgt_q, tgt_d;
   logic [PWM_STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
   logic                      done_q, done_d;
   logic                      bnd, hs;
   logic [WIDTH-1:0]          step_val;
   logic [WIDTH-1:0]          cnt_unused;

   // One step toward tgt, clamped at tgt; the sum is kept one bit wider so it cannot wrap.
   function automatic logic [WIDTH-1:0] ramp_toward(input logic [WIDTH-1:0] cur,
                                                    input logic [WIDTH-1:0] tgt);
      logic [WIDTH:0] sum;
      logic [WIDTH:0] gap;
      sum = {1'b0, cur} + STEP_X;
      gap = {1'b0, cur} - {1'b0, tgt};
      if (tgt > cur) ramp_toward = (sum >= {1'b0, tgt}) ? tgt : sum[WIDTH-1:0];
      else           ramp_toward = (gap <= STEP_X) ? tgt : cur - STEP_X[WIDTH-1:0];
   endfunction

   pwm_period_cnt #(.WIDTH(WIDTH)) u_period_cnt (
      .clk            (clk),
      .rst            (rst),
      .cnt_o          (cnt_unused),
      .bnd_o          (bnd),
      .period_start_o (period_start)
   );

   assign hs       = tgt_valid && tgt_ready;
   assign step_val = ramp_toward(duty_q, tgt_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= PWM_IDLE;
         duty_q     <= '0;
         step_cnt_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         duty_q     <= duty_d;
         step_cnt_q <= step_cnt_d;
         done_q     <= done_d;
      end
   end

   always_ff @(posedge clk) tgt_q <= tgt_d;

   always_comb begin
      state_d    = state_q;
      duty_d     = duty_q;
      tgt_d      = tgt_q;
      step_cnt_d = step_cnt_q;
      done_d     = 1'b0;
      case (state_q)
         PWM_IDLE: begin
            if (enable) state_d = PWM_HOLD;
         end
         PWM_HOLD: begin
            if (hs) begin
               tgt_d      = tgt_duty;
               step_cnt_d = '0;
               if (tgt_duty == duty_q) done_d  = 1'b1;
               else                    state_d = PWM_RAMP;
            end
         end
         PWM_RAMP: begin
            if (bnd) begin
               if (step_cnt_q == LAST_STEP) begin
                  step_cnt_d = '0;
                  duty_d     = step_val;
                  if (step_val == tgt_q) begin
                     state_d = PWM_HOLD;
                     done_d  = 1'b1;
                  end
               end else begin
                  step_cnt_d = step_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = PWM_IDLE;
      endcase
      // Shutdown waits for the boundary so the last pulse is never truncated.
      if (bnd && !enable) begin
         state_d = PWM_IDLE;
         duty_d  = '0;
         done_d  = 1'b0;
      end
   end

   always_comb begin
      tgt_ready = (state_q == PWM_HOLD);
      busy      = (state_q == PWM_RAMP);
      duty_out  = duty_q;
      done      = done_q;
   end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: a default instance and a STEP=200 / STEP_PERIODS=3 instance, randomized targets.
module tb_pwm_ramp_ctrl;
   localparam int P = 256;

   logic       clk = 1'b0;
   logic       rst, enable, vld_a, vld_b;
   logic [7:0] tgt_duty;
   logic       rdy_a, ps_a, busy_a, done_a;
   logic       rdy_b, ps_b, busy_b, done_b;
   logic [7:0] duty_a, duty_b;
   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   int         cur [2];

   pwm_ramp_ctrl u_a (
      .clk(clk), .rst(rst), .enable(enable), .tgt_valid(vld_a), .tgt_duty(tgt_duty),
      .tgt_ready(rdy_a), .duty_out(duty_a), .period_start(ps_a), .busy(busy_a), .done(done_a)
   );

   pwm_ramp_ctrl #(.STEP(200), .STEP_PERIODS(3)) u_b (
      .clk(clk), .rst(rst), .enable(enable), .tgt_valid(vld_b), .tgt_duty(tgt_duty),
      .tgt_ready(rdy_b), .duty_out(duty_b), .period_start(ps_b), .busy(busy_b), .done(done_b)
   );

   always #5 clk = ~clk;

   // Cycles since reset release; the period phase is cyc mod 256.
   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   function automatic int step_of(input int s);
      return (s != 0) ? 200 : 16;
   endfunction

   function automatic int sp_of(input int s);
      return (s != 0) ? 3 : 1;
   endfunction

   function automatic int next_duty(input int d, input int t, input int st);
      if (t > d) return (d + st > t) ? t : d + st;
      return (d - st < t) ? t : d - st;
   endfunction

   function automatic logic [11:0] obs(input int s);
      return (s != 0) ? {duty_b, busy_b, rdy_b, done_b, ps_b} : {duty_a, busy_a, rdy_a, done_a, ps_a};
   endfunction

   function automatic logic [11:0] ex(input int d, input bit b, input bit r, input bit dn);
      return {8'(d), b, r, dn, (cyc % P) == 0};
   endfunction

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic reset_and_check(input string tag);
      logic [11:0] g, w;
      @(negedge clk);
      rst = 1'b1; vld_a = 1'b0; vld_b = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         g = obs(s); w = ex(0, 0, 0, 0); total++;
         if (g !== w || cyc != 0) begin bad++; $display("FAIL %s_values s=%0d cyc=%0d got duty=%0d b/r/d/ps=%b want duty=%0d b/r/d/ps=%b", tag, s, cyc, g[11:4], g[3:0], w[11:4], w[3:0]); end
      end
      rst = 1'b0; enable = 1'b0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         g = obs(s); w = ex(0, 0, 0, 0); total++;
         if (g !== w) begin bad++; $display("FAIL %s_idle s=%0d cyc=%0d got duty=%0d b/r/d/ps=%b want duty=%0d b/r/d/ps=%b", tag, s, cyc, g[11:4], g[3:0], w[11:4], w[3:0]); end
      end
      enable = 1'b1;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         g = obs(s); w = ex(0, 0, 1, 0); total++;
         if (g !== w) begin bad++; $display("FAIL %s_hold s=%0d cyc=%0d got duty=%0d b/r/d/ps=%b want duty=%0d b/r/d/ps=%b", tag, s, cyc, g[11:4], g[3:0], w[11:4], w[3:0]); end
      end
      cur[0] = 0; cur[1] = 0;
   endtask

   // mode 0: full ramp; 1: enable glitch before step 2; 2: enable drop before step 4; 3: reset before step 2
   task automatic run_ramp(input int s, input int t, input int mode);
      int seq[$];
      int d, hs, b1, vis, prev, sp;
      logic [11:0] g, w;
      sp = sp_of(s);
      d  = cur[s];
      while (d != t) begin d = next_duty(d, t, step_of(s)); seq.push_back(d); end
      g = obs(s); w = ex(cur[s], 0, 1, 0); total++;
      if (g !== w) begin bad++; $display("FAIL pre_handshake s=%0d cyc=%0d got duty=%0d b/r/d/ps=%b want duty=%0d b/r/d/ps=%b", s, cyc, g[11:4], g[3:0], w[11:4], w[3:0]); end
      tgt_duty = 8'(t);
      if (s != 0) vld_b = 1'b1; else vld_a = 1'b1;
      hs = cyc;
      @(negedge clk);
      vld_a = 1'b0; vld_b = 1'b0;
      if (seq.size() == 0) begin
         g = obs(s); w = ex(cur[s], 0, 1, 1); total++;
         if (g !== w) begin bad++; $display("FAIL same_target_done s=%0d cyc=%0d got duty=%0d b/r/d/ps=%b want duty=%0d b/r/d/ps=%b", s, cyc, g[11:4], g[3:0], w[11:4], w[3:0]); end
         @(negedge clk);
         g = obs(s); w = ex(cur[s], 0, 1, 0); total++;
         if (g !== w) begin bad++; $display("FAIL same_target_after s=%0d cyc=%0d got duty=%0d b/r/d/ps=%b want duty=%0d b/r/d/ps=%b", s, cyc, g[11:4], g[3:0], w[11:4], w[3:0]); end
         return;
      end
      g = obs(s); w = ex(cur[s], 1, 0, 0); total++;
      if (g !== w) begin bad++; $display("FAIL ramp_entry s=%0d cyc=%0d got duty=%0d b/r/d/ps=%b want duty=%0d b/r/d/ps=%b", s, cyc, g[11:4], g[3:0], w[11:4], w[3:0]); end
      b1 = hs + 1;
      while (b1 % P != P - 1) b1++;
      prev = cur[s];
      foreach (seq[k]) begin
         vis = b1 + ((k + 1) * sp - 1) * P + 1;
         if (mode == 1 && k == 1) begin
            wait_cyc(vis - 100); enable = 1'b0;
            wait_cyc(vis - 90);  enable = 1'b1;
         end
         if (mode == 3 && k == 1) begin
            wait_cyc(vis - int'($urandom_range(2, 200)));
            reset_and_check("reset_mid_ramp");
            return;
         end
         if (mode == 2 && k == 3) begin
            wait_cyc(vis - 1 - int'($urandom_range(1, 200)));
            enable = 1'b0;
         end
         wait_cyc(vis - 1);
         g = obs(s); w = ex(prev, 1, 0, 0); total++;
         if (g !== w) begin bad++; $display("FAIL before_step%0d s=%0d cyc=%0d got duty=%0d b/r/d/ps=%b want duty=%0d b/r/d/ps=%b", k, s, cyc, g[11:4], g[3:0], w[11:4], w[3:0]); end
         wait_cyc(vis);
         if (mode == 2 && k == 3) begin
            for (int i = 0; i < 2; i++) begin
               g = obs(i); w = ex(0, 0, 0, 0); total++;
               if (g !== w) begin bad++; $display("FAIL enable_drop_zero s=%0d cyc=%0d got duty=%0d b/r/d/ps=%b want duty=%0d b/r/d/ps=%b", i, cyc, g[11:4], g[3:0], w[11:4], w[3:0]); end
            end
            @(negedge clk);
            g = obs(s); w = ex(0, 0, 0, 0); total++;
            if (g !== w) begin bad++; $display("FAIL enable_drop_no_done s=%0d cyc=%0d got duty=%0d b/r/d/ps=%b want duty=%0d b/r/d/ps=%b", s, cyc, g[11:4], g[3:0], w[11:4], w[3:0]); end
            enable = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
               g = obs(i); w = ex(0, 0, 1, 0); total++;
               if (g !== w) begin bad++; $display("FAIL reenable_hold s=%0d cyc=%0d got duty=%0d b/r/d/ps=%b want duty=%0d b/r/d/ps=%b", i, cyc, g[11:4], g[3:0], w[11:4], w[3:0]); end
            end
            cur[0] = 0; cur[1] = 0;
            return;
         end
         if (k == seq.size() - 1) w = ex(seq[k], 0, 1, 1);
         else                     w = ex(seq[k], 1, 0, 0);
         g = obs(s); total++;
         if (g !== w) begin bad++; $display("FAIL step%0d s=%0d cyc=%0d got duty=%0d b/r/d/ps=%b want duty=%0d b/r/d/ps=%b", k, s, cyc, g[11:4], g[3:0], w[11:4], w[3:0]); end
         prev = seq[k];
      end
      @(negedge clk);
      g = obs(s); w = ex(t, 0, 1, 0); total++;
      if (g !== w) begin bad++; $display("FAIL after_done s=%0d cyc=%0d got duty=%0d b/r/d/ps=%b want duty=%0d b/r/d/ps=%b", s, cyc, g[11:4], g[3:0], w[11:4], w[3:0]); end
      cur[s] = t;
   endtask

   task automatic test_reset();
      reset_and_check("reset");
   endtask

   task automatic test_period();
      logic [11:0] g, w;
      repeat (600) begin
         @(negedge clk);
         for (int s = 0; s < 2; s++) begin
            g = obs(s); w = ex(cur[s], 0, 1, 0); total++;
            if (g !== w) begin bad++; $display("FAIL period_hold s=%0d cyc=%0d got duty=%0d b/r/d/ps=%b want duty=%0d b/r/d/ps=%b", s, cyc, g[11:4], g[3:0], w[11:4], w[3:0]); end
         end
      end
   endtask

   task automatic test_enable_drop();
      run_ramp(0, 200, 2);
   endtask

   task automatic test_ramp_up();
      run_ramp(0, 100, 0);
   endtask

   task automatic test_saturation();
      run_ramp(1, 100, 0);
      run_ramp(1, 255, 0);
      run_ramp(1, 255, 0);
   endtask

   task automatic test_ramp_down();
      run_ramp(0, 10, 0);
      run_ramp(1, 10, 0);
   endtask

   task automatic test_bnd_handshake();
      int n;
      n = cyc + (P - 1 - cyc % P);
      wait_cyc(n);
      run_ramp(0, (cur[0] < 128) ? 200 : 20, 0);
   endtask

   task automatic test_enable_glitch();
      run_ramp(0, (cur[0] < 128) ? 250 : 5, 1);
   endtask

   task automatic test_random();
      int s, t;
      for (int i = 0; i < 6; i++) begin
         s = int'($urandom_range(0, 1));
         t = (i == 2) ? cur[s] : int'($urandom_range(0, 255));
         wait_cyc(cyc + int'($urandom_range(0, 300)));
         run_ramp(s, t, 0);
      end
   endtask

   task automatic test_reset_mid_ramp();
      run_ramp(0, (cur[0] < 128) ? 250 : 0, 3);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; vld_a = 1'b0; vld_b = 1'b0; tgt_duty = 8'd0;
      cur[0] = 0; cur[1] = 0;
      test_reset();
      test_period();
      test_enable_drop();
      test_ramp_up();
      test_saturation();
      test_ramp_down();
      test_bnd_handshake();
      test_enable_glitch();
      test_random();
      test_reset_mid_ramp();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
